// File: rtl/bp_io_cmd_arbiter_pkg.sv
// Shared types and helpers for the I/O command arbiter: FSM state encoding
// and the round-robin pick used while no grant is held.
package bp_io_cmd_arbiter_pkg;

   // One packed BedRock memory message: 512-bit data plus a 64-bit header.
   localparam int unsigned BP_IO_MSG_WIDTH = 576;
   localparam int unsigned BP_IO_MAX_REQ   = 8;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } arb_state_e;

   // Returns the first valid requester at or after ptr, wrapping modulo n.
   // Returns 0 when nothing is valid; the caller gates on the OR of valids.
   function automatic int rrPick(input logic [BP_IO_MAX_REQ-1:0] valid,
                                 input int ptr,
                                 input int n);
      int idx;
      rrPick = 0;
      for (int k = BP_IO_MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = (ptr + k) % n;
            if (valid[idx]) rrPick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/bp_io_cmd_arbiter_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per command issued but not yet
// answered; the head names the owner of the next returning response.
module bp_io_cmd_arbiter_tag_fifo
   import bp_io_cmd_arbiter_pkg::*;
#(
   parameter int unsigned width_p = 1,
   parameter int unsigned els_p   = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         i_push,
   input  logic [width_p-1:0]           i_data,
   input  logic                         i_pop,
   output logic [width_p-1:0]           o_head,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(els_p+1)-1:0]   o_count
);

   localparam int unsigned PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int unsigned CNT_W = $clog2(els_p + 1);

   logic [width_p-1:0] r_mem [els_p];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == CNT_W'(els_p));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      nextPtr = (p == PTR_W'(els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= nextPtr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= nextPtr(r_rd_ptr);
         if (w_push & ~w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/bp_io_cmd_arbiter.sv
// Shares one I/O command/response channel between several requesters:
// round-robin command issue with a held grant, in-order response routing.
module bp_io_cmd_arbiter
   import bp_io_cmd_arbiter_pkg::*;
#(
   parameter int unsigned num_req_p         = 2,
   parameter int unsigned msg_width_p       = BP_IO_MSG_WIDTH,
   parameter int unsigned max_outstanding_p = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [num_req_p*msg_width_p-1:0]       req_cmd_i,
   input  logic [num_req_p-1:0]                   req_cmd_v_i,
   output logic [num_req_p-1:0]                   req_cmd_yumi_o,
   output logic [msg_width_p-1:0]                 req_resp_o,
   output logic [num_req_p-1:0]                   req_resp_v_o,
   input  logic [num_req_p-1:0]                   req_resp_ready_i,
   output logic [msg_width_p-1:0]                 cmd_o,
   output logic                                   cmd_v_o,
   input  logic                                   cmd_ready_i,
   input  logic [msg_width_p-1:0]                 resp_i,
   input  logic                                   resp_v_i,
   output logic                                   resp_yumi_o,
   output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
   output logic                                   error_o
);

   localparam int unsigned ID_W = $clog2(num_req_p);
   localparam logic [num_req_p-1:0] ONE_HOT0 = num_req_p'(1);

   arb_state_e      r_state;
   logic [ID_W-1:0] r_held_id;
   logic [ID_W-1:0] r_rr_ptr;
   logic            r_error;

   logic [ID_W-1:0] w_pick;
   logic [ID_W-1:0] w_winner;
   logic [ID_W-1:0] w_next_ptr;
   logic [ID_W-1:0] w_head;
   logic            w_xfer;
   logic            w_resp_ok;
   logic            w_tag_full;
   logic            w_tag_empty;

   assign w_pick   = ID_W'(rrPick(BP_IO_MAX_REQ'(req_cmd_v_i), int'(r_rr_ptr), int'(num_req_p)));
   assign w_winner = (r_state == ST_LOCKED) ? r_held_id : w_pick;

   // While locked, no push has happened since the grant was offered, so tag
   // space is still guaranteed and the full check is bypassed.
   assign cmd_v_o = (r_state == ST_LOCKED) ? 1'b1 : ((|req_cmd_v_i) & ~w_tag_full);
   assign cmd_o   = req_cmd_i[int'(w_winner)*msg_width_p +: msg_width_p];
   assign w_xfer  = cmd_v_o & cmd_ready_i;

   assign req_cmd_yumi_o = w_xfer ? (ONE_HOT0 << w_winner) : '0;
   assign w_next_ptr     = (w_winner == ID_W'(num_req_p - 1)) ? '0 : w_winner + 1'b1;

   assign w_resp_ok    = resp_v_i & ~w_tag_empty;
   assign req_resp_o   = resp_i;
   assign req_resp_v_o = w_resp_ok ? (ONE_HOT0 << w_head) : '0;
   assign resp_yumi_o  = w_resp_ok & req_resp_ready_i[w_head];
   assign error_o      = r_error;

   bp_io_cmd_arbiter_tag_fifo #(
      .width_p (ID_W),
      .els_p   (max_outstanding_p)
   ) tagFifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .i_push  (w_xfer),
      .i_data  (w_winner),
      .i_pop   (resp_yumi_o),
      .o_head  (w_head),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (outstanding_o)
   );

   // Grant lock, round-robin pointer and the sticky orphan-response flag.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= ST_IDLE;
         r_held_id <= '0;
         r_rr_ptr  <= '0;
         r_error   <= 1'b0;
      end else begin
         if (resp_v_i & w_tag_empty) r_error <= 1'b1;
         if (w_xfer) r_rr_ptr <= w_next_ptr;
         case (r_state)
            ST_IDLE: begin
               if (cmd_v_o & ~cmd_ready_i) begin
                  r_state   <= ST_LOCKED;
                  r_held_id <= w_winner;
               end
            end
            ST_LOCKED: begin
               if (cmd_ready_i) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_io_cmd_arbiter.sv
// Directed bench for bp_io_cmd_arbiter: a vector table for steady-state
// arbitration and routing, plus sequences for stall, full, and error cases.
module tb_bp_io_cmd_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 16;
   localparam int MAXO = 4;

   localparam logic [W-1:0] DATA0 = 16'hA0A0;
   localparam logic [W-1:0] DATA1 = 16'hB1B1;
   localparam logic [W-1:0] RESPD = 16'hC3C3;

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic [NREQ*W-1:0] req_cmd_i;
   logic [NREQ-1:0] req_cmd_v_i;
   logic [NREQ-1:0] req_cmd_yumi_o;
   logic [W-1:0]    req_resp_o;
   logic [NREQ-1:0] req_resp_v_o;
   logic [NREQ-1:0] req_resp_ready_i;
   logic [W-1:0]    cmd_o;
   logic            cmd_v_o;
   logic            cmd_ready_i;
   logic [W-1:0]    resp_i;
   logic            resp_v_i;
   logic            resp_yumi_o;
   logic [2:0]      outstanding_o;
   logic            error_o;

   int checks = 0;
   int passed = 0;

   always #5 clk_i = ~clk_i;

   bp_io_cmd_arbiter #(
      .num_req_p         (NREQ),
      .msg_width_p       (W),
      .max_outstanding_p (MAXO)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .req_cmd_i        (req_cmd_i),
      .req_cmd_v_i      (req_cmd_v_i),
      .req_cmd_yumi_o   (req_cmd_yumi_o),
      .req_resp_o       (req_resp_o),
      .req_resp_v_o     (req_resp_v_o),
      .req_resp_ready_i (req_resp_ready_i),
      .cmd_o            (cmd_o),
      .cmd_v_o          (cmd_v_o),
      .cmd_ready_i      (cmd_ready_i),
      .resp_i           (resp_i),
      .resp_v_i         (resp_v_i),
      .resp_yumi_o      (resp_yumi_o),
      .outstanding_o    (outstanding_o),
      .error_o          (error_o)
   );

   typedef struct {
      logic [1:0]  v;
      logic        rdy;
      logic        rv;
      logic [1:0]  rr;
      logic        expCmdV;
      logic [1:0]  expYumi;
      logic        chkData;
      logic [15:0] expCmd;
      logic [1:0]  expRespV;
      logic        expRespYumi;
      logic [2:0]  expOut;
   } vec_t;

   vec_t vecs[11];

   // Compare one value; every call counts as a check.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Drive one cycle of inputs just after the falling edge and let them settle.
   task automatic applyStimulus(input logic [1:0] v, input logic rdy, input logic rv, input logic [1:0] rr);
      @(negedge clk_i);
      req_cmd_v_i      = v;
      cmd_ready_i      = rdy;
      resp_v_i         = rv;
      req_resp_ready_i = rr;
      #1;
   endtask

   task automatic checkCycle(input string tag, input logic cv, input logic [1:0] y,
                             input logic [1:0] rvo, input logic ry, input logic [2:0] o);
      checkOutput({tag, ".cmd_v"},     32'(cmd_v_o),        32'(cv));
      checkOutput({tag, ".yumi"},      32'(req_cmd_yumi_o), 32'(y));
      checkOutput({tag, ".resp_v"},    32'(req_resp_v_o),   32'(rvo));
      checkOutput({tag, ".resp_yumi"}, 32'(resp_yumi_o),    32'(ry));
      checkOutput({tag, ".outst"},     32'(outstanding_o),  32'(o));
   endtask

   initial begin
      vecs[0]  = '{2'b11, 1, 0, 2'b00, 1, 2'b01, 1, DATA0, 2'b00, 0, 3'd0};
      vecs[1]  = '{2'b11, 1, 0, 2'b00, 1, 2'b10, 1, DATA1, 2'b00, 0, 3'd1};
      vecs[2]  = '{2'b11, 1, 1, 2'b11, 1, 2'b01, 1, DATA0, 2'b01, 1, 3'd2};
      vecs[3]  = '{2'b00, 1, 1, 2'b11, 0, 2'b00, 0, 16'h0, 2'b10, 1, 3'd2};
      vecs[4]  = '{2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 16'h0, 2'b01, 1, 3'd1};
      vecs[5]  = '{2'b10, 1, 0, 2'b00, 1, 2'b10, 1, DATA1, 2'b00, 0, 3'd0};
      vecs[6]  = '{2'b10, 1, 0, 2'b00, 1, 2'b10, 1, DATA1, 2'b00, 0, 3'd1};
      vecs[7]  = '{2'b00, 1, 1, 2'b01, 0, 2'b00, 0, 16'h0, 2'b10, 0, 3'd2};
      vecs[8]  = '{2'b00, 1, 1, 2'b10, 0, 2'b00, 0, 16'h0, 2'b10, 1, 3'd2};
      vecs[9]  = '{2'b00, 1, 1, 2'b10, 0, 2'b00, 0, 16'h0, 2'b10, 1, 3'd1};
      vecs[10] = '{2'b00, 1, 0, 2'b00, 0, 2'b00, 0, 16'h0, 2'b00, 0, 3'd0};

      req_cmd_i        = {DATA1, DATA0};
      resp_i           = RESPD;
      reset_i          = 1'b1;
      req_cmd_v_i      = '0;
      cmd_ready_i      = 1'b0;
      resp_v_i         = 1'b0;
      req_resp_ready_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b0;
      #1;
      checkCycle("reset", 0, 2'b00, 2'b00, 0, 3'd0);
      checkOutput("reset.error", 32'(error_o), 32'd0);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].v, vecs[i].rdy, vecs[i].rv, vecs[i].rr);
         checkCycle($sformatf("vec%0d", i), vecs[i].expCmdV, vecs[i].expYumi,
                    vecs[i].expRespV, vecs[i].expRespYumi, vecs[i].expOut);
         if (vecs[i].chkData) checkOutput($sformatf("vec%0d.cmd", i), 32'(cmd_o), 32'(vecs[i].expCmd));
         if (vecs[i].expRespV != 2'b00) checkOutput($sformatf("vec%0d.rdata", i), 32'(req_resp_o), 32'(RESPD));
      end

      // Held grant: move the pointer to req1, then stall a req0 grant.
      applyStimulus(2'b01, 1, 0, 2'b00);
      checkCycle("prep", 1, 2'b01, 2'b00, 0, 3'd0);
      applyStimulus(2'b00, 1, 1, 2'b11);
      checkCycle("prepResp", 0, 2'b00, 2'b01, 1, 3'd1);
      applyStimulus(2'b01, 0, 0, 2'b00);
      checkCycle("stall0", 1, 2'b00, 2'b00, 0, 3'd0);
      checkOutput("stall0.cmd", 32'(cmd_o), 32'(DATA0));
      for (int i = 1; i < 4; i++) begin
         applyStimulus(2'b11, 0, 0, 2'b00);
         checkCycle($sformatf("stall%0d", i), 1, 2'b00, 2'b00, 0, 3'd0);
         checkOutput($sformatf("stall%0d.cmd", i), 32'(cmd_o), 32'(DATA0));
      end
      applyStimulus(2'b11, 1, 0, 2'b00);
      checkCycle("release0", 1, 2'b01, 2'b00, 0, 3'd0);
      checkOutput("release0.cmd", 32'(cmd_o), 32'(DATA0));
      applyStimulus(2'b11, 1, 0, 2'b00);
      checkCycle("release1", 1, 2'b10, 2'b00, 0, 3'd1);
      checkOutput("release1.cmd", 32'(cmd_o), 32'(DATA1));
      applyStimulus(2'b00, 1, 1, 2'b11);
      checkCycle("drainA", 0, 2'b00, 2'b01, 1, 3'd2);
      applyStimulus(2'b00, 1, 1, 2'b11);
      checkCycle("drainB", 0, 2'b00, 2'b10, 1, 3'd1);

      // Fill the tag FIFO; a same-cycle pop must not let a push through.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b01, 1, 0, 2'b00);
         checkCycle($sformatf("fill%0d", i), 1, 2'b01, 2'b00, 0, 3'(i));
      end
      applyStimulus(2'b01, 1, 0, 2'b00);
      checkCycle("full", 0, 2'b00, 2'b00, 0, 3'd4);
      applyStimulus(2'b01, 1, 1, 2'b01);
      checkCycle("fullPop", 0, 2'b00, 2'b01, 1, 3'd4);
      applyStimulus(2'b01, 1, 0, 2'b00);
      checkCycle("resume", 1, 2'b01, 2'b00, 0, 3'd3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b00, 1, 1, 2'b01);
         checkCycle($sformatf("drainF%0d", i), 0, 2'b00, 2'b01, 1, 3'(4 - i));
      end

      // Orphan response sets the sticky error; reset clears everything.
      applyStimulus(2'b00, 1, 1, 2'b11);
      checkCycle("orphan", 0, 2'b00, 2'b00, 0, 3'd0);
      applyStimulus(2'b00, 1, 0, 2'b00);
      checkOutput("errSet", 32'(error_o), 32'd1);
      applyStimulus(2'b00, 1, 0, 2'b00);
      checkOutput("errSticky", 32'(error_o), 32'd1);
      applyStimulus(2'b01, 1, 0, 2'b00);
      checkCycle("preReset", 1, 2'b01, 2'b00, 0, 3'd0);
      applyStimulus(2'b00, 0, 0, 2'b00);
      reset_i = 1'b1;
      applyStimulus(2'b11, 1, 0, 2'b00);
      reset_i = 1'b0;
      #1;
      checkOutput("postReset.error", 32'(error_o), 32'd0);
      checkCycle("postReset", 1, 2'b01, 2'b00, 0, 3'd0);
      checkOutput("postReset.cmd", 32'(cmd_o), 32'(DATA0));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
